// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares the CPU writeback debug trace against a FIFO of
// expected records and latches a pass/fail verdict with the first mismatch.
module wb_trace_checker #(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] END_PC = 32'h1c000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [31:0] exp_pc,
    input  logic [4:0]  exp_wnum,
    input  logic [31:0] exp_wdata,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_we,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        underflow,
    output logic [31:0] err_pc,
    output logic [4:0]  err_wnum,
    output logic [31:0] err_wdata,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] cmp_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_mem_pc    [DEPTH];
    logic [4:0]  r_mem_wnum  [DEPTH];
    logic [31:0] r_mem_wdata [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;

    logic        w_push, w_cmp, w_empty, w_pop, w_bad, w_fail_evt, w_end;
    logic [31:0] w_hpc, w_hwdata;
    logic [4:0]  w_hwnum;

    assign exp_ready  = r_count != FULL;
    assign w_empty    = r_count == '0;
    assign w_push     = exp_valid && exp_ready;
    assign w_cmp      = r_state == S_RUN && debug_wb_rf_we != 4'b0 && debug_wb_rf_wnum != 5'd0;
    assign w_pop      = w_cmp && !w_empty;
    assign w_hpc      = r_mem_pc[r_rptr];
    assign w_hwnum    = r_mem_wnum[r_rptr];
    assign w_hwdata   = r_mem_wdata[r_rptr];
    assign w_bad      = w_hpc != debug_wb_pc || w_hwnum != debug_wb_rf_wnum || w_hwdata != debug_wb_rf_wdata;
    // An empty FIFO on a compare is itself a failure; no same-cycle bypass.
    assign w_fail_evt = w_cmp && (w_empty || w_bad);
    assign w_end      = r_state == S_RUN && debug_wb_pc == END_PC;

    assign busy = r_state == S_RUN;
    assign pass = r_state == S_PASS;
    assign fail = r_state == S_FAIL;
    assign done = pass || fail;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == S_IDLE && start)
            w_next = S_RUN;
        else if (r_state == S_RUN)
            w_next = w_fail_evt ? S_FAIL : w_end ? S_PASS : S_RUN;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]    <= exp_pc;
            r_mem_wnum[r_wptr]  <= exp_wnum;
            r_mem_wdata[r_wptr] <= exp_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            underflow     <= 1'b0;
            err_pc        <= '0;
            err_wnum      <= '0;
            err_wdata     <= '0;
            err_exp_wdata <= '0;
            cmp_count     <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop)
                r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_fail_evt) begin
                underflow     <= w_empty;
                err_pc        <= debug_wb_pc;
                err_wnum      <= debug_wb_rf_wnum;
                err_wdata     <= debug_wb_rf_wdata;
                err_exp_wdata <= w_empty ? 32'd0 : w_hwdata;
            end
            if (w_pop && !w_bad)
                cmp_count <= cmp_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed and randomized runs of wb_trace_checker against
// a queue-based reference model; a monitor compares every cycle's outputs.
module tb_wb_trace_checker;
    localparam int          D   = 4;
    localparam logic [31:0] END = 32'h1c000100;

    logic        clk = 0, reset, start, exp_valid, exp_ready;
    logic [31:0] exp_pc, exp_wdata, debug_wb_pc, debug_wb_rf_wdata;
    logic [4:0]  exp_wnum, debug_wb_rf_wnum;
    logic [3:0]  debug_wb_rf_we;
    logic        busy, done, pass, fail, underflow;
    logic [31:0] err_pc, err_wdata, err_exp_wdata, cmp_count;
    logic [4:0]  err_wnum;

    wb_trace_checker #(.DEPTH(D), .END_PC(END)) dut (
        .clk(clk), .reset(reset), .start(start), .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_pc(exp_pc), .exp_wnum(exp_wnum), .exp_wdata(exp_wdata),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .underflow(underflow),
        .err_pc(err_pc), .err_wnum(err_wnum), .err_wdata(err_wdata),
        .err_exp_wdata(err_exp_wdata), .cmp_count(cmp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] pc; logic [4:0] wn; logic [31:0] wd;} rec_t;
    typedef struct packed {
        logic rdy, busy, done, pass, fail, uf;
        logic [31:0] epc; logic [4:0] ewn; logic [31:0] ewd, eexp, cnt;
    } snap_t;

    rec_t  mq[$];
    snap_t sq[$];
    int    m_st;
    logic  m_uf;
    logic [31:0] m_epc, m_ewd, m_eexp, m_cnt;
    logic [4:0]  m_ewn;
    int checks = 0, errors = 0, cycle = 0;

    task automatic cyc(input bit r, input bit s, input bit v, input logic [31:0] epc,
                       input logic [4:0] ewn, input logic [31:0] ewd, input logic [31:0] pc,
                       input logic [3:0] we, input logic [4:0] wn, input logic [31:0] wd);
        bit rdy, c, bad;
        rec_t h;
        @(negedge clk);
        reset = r; start = s; exp_valid = v; exp_pc = epc; exp_wnum = ewn; exp_wdata = ewd;
        debug_wb_pc = pc; debug_wb_rf_we = we; debug_wb_rf_wnum = wn; debug_wb_rf_wdata = wd;
        if (r) begin
            mq.delete(); m_st = 0; m_uf = 0; m_epc = 0; m_ewn = 0; m_ewd = 0; m_eexp = 0; m_cnt = 0;
        end else begin
            rdy = mq.size() < D;
            c   = m_st == 1 && we != 0 && wn != 0;
            bad = 0;
            if (c) begin
                if (mq.size() == 0) begin
                    bad = 1; m_uf = 1; m_eexp = 0;
                end else begin
                    h = mq.pop_front();
                    if (h.pc != pc || h.wn != wn || h.wd != wd) begin
                        bad = 1; m_uf = 0; m_eexp = h.wd;
                    end else
                        m_cnt = m_cnt + 1;
                end
                if (bad) begin m_epc = pc; m_ewn = wn; m_ewd = wd; end
            end
            if (v && rdy) mq.push_back({epc, ewn, ewd});
            if (m_st == 0 && s) m_st = 1;
            else if (m_st == 1) m_st = bad ? 3 : (pc == END) ? 2 : 1;
        end
        sq.push_back({mq.size() < D, m_st == 1, m_st >= 2, m_st == 2, m_st == 3, m_uf,
                      m_epc, m_ewn, m_ewd, m_eexp, m_cnt});
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", n, cycle, a, e);
        end
    endtask

    initial forever begin
        snap_t e;
        @(posedge clk);
        #1;
        cycle++;
        if (sq.size() > 0) begin
            e = sq.pop_front();
            chk("exp_ready", 32'(exp_ready), 32'(e.rdy));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
            chk("pass", 32'(pass), 32'(e.pass));
            chk("fail", 32'(fail), 32'(e.fail));
            chk("underflow", 32'(underflow), 32'(e.uf));
            chk("err_pc", err_pc, e.epc);
            chk("err_wnum", 32'(err_wnum), 32'(e.ewn));
            chk("err_wdata", err_wdata, e.ewd);
            chk("err_exp_wdata", err_exp_wdata, e.eexp);
            chk("cmp_count", cmp_count, e.cnt);
        end
    end

    task automatic push(input logic [31:0] pc, input logic [4:0] wn, input logic [31:0] wd);
        cyc(0, 0, 1, pc, wn, wd, 0, 0, 0, 0);
    endtask

    task automatic wb(input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wn, input logic [31:0] wd);
        cyc(0, 0, 0, 0, 0, 0, pc, we, wn, wd);
    endtask

    task automatic rst1(); cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic go(); cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic push3();
        push(32'h1c000004, 1, 5); push(32'h1c000008, 2, 7); push(32'h1c00000c, 3, 32'hc);
    endtask

    function automatic logic [31:0] rpc();
        return 32'h1c000000 + 32'($urandom_range(0, 63)) * 4;
    endfunction

    initial begin
        rec_t h;
        int m;
        rst1(); rst1();
        push3(); go();
        wb(32'h1c000004, 4'hf, 1, 5); wb(32'h1c000008, 4'hf, 2, 7); wb(32'h1c00000c, 4'hf, 3, 32'hc);
        wb(END, 0, 0, 0); wb(0, 0, 0, 0);

        rst1(); push3(); go();
        wb(32'h1c000004, 4'hf, 1, 5); wb(32'h1c000008, 4'hf, 2, 8); wb(32'h1c00000c, 4'hf, 3, 32'hc);
        wb(END, 0, 0, 0); wb(0, 0, 0, 0);

        rst1(); push(32'h1c000010, 6, 32'h66); go();
        wb(32'h1c000014, 4'hf, 0, 1); wb(32'h1c000018, 0, 5, 2);
        wb(32'h1c000010, 4'h1, 6, 32'h66); wb(32'h1c00001c, 4'hf, 7, 3);

        rst1(); go(); wb(32'h1c000020, 4'hf, 4, 9); wb(0, 0, 0, 0);

        rst1();
        for (int i = 0; i < D; i++) push(32'h1c000040 + 32'(i) * 4, 5'(i + 1), 32'(i * 3));
        cyc(0, 1, 1, 32'hdead0000, 9, 9, 0, 0, 0, 0);
        cyc(0, 0, 1, 32'hbeef0000, 9, 9, 32'h1c000040, 4'hf, 1, 0);
        wb(0, 0, 0, 0);
        for (int i = 1; i < D; i++) wb(32'h1c000040 + 32'(i) * 4, 4'h3, 5'(i + 1), 32'(i * 3));
        wb(32'h1c000080, 4'hf, 9, 9);

        rst1(); push3(); go();
        wb(32'h1c000004, 4'hf, 1, 6);
        rst1();
        wb(32'h1c000008, 4'hf, 2, 7); go(); wb(32'h1c000008, 4'hf, 2, 7); wb(0, 0, 0, 0);

        for (int run = 0; run < 30; run++) begin
            rst1();
            for (int i = $urandom_range(0, D + 1); i > 0; i--)
                push(rpc(), 5'($urandom_range(1, 31)), $urandom);
            go();
            for (int i = 0; i < 40; i++) begin
                m = $urandom_range(0, 99);
                if (m < 40 && mq.size() > 0) begin
                    h = mq[0];
                    cyc(0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, rpc(),
                        5'($urandom_range(1, 31)), $urandom, h.pc, 4'($urandom_range(1, 15)), h.wn, h.wd);
                end else if (m < 43 && mq.size() > 0) begin
                    h = mq[0];
                    cyc(0, 0, 0, 0, 0, 0, h.pc, 4'hf, h.wn, h.wd ^ 32'h100);
                end else if (m < 46)
                    cyc(0, 0, $urandom_range(0, 1) == 1, rpc(), 5'($urandom_range(1, 31)), $urandom,
                        END, 4'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
                else if (m < 60)
                    cyc(0, 0, $urandom_range(0, 1) == 1, rpc(), 5'($urandom_range(1, 31)), $urandom,
                        rpc(), 4'($urandom_range(1, 15)), 0, $urandom);
                else if (m < 95)
                    cyc(0, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, rpc(),
                        5'($urandom_range(1, 31)), $urandom, rpc(), 0, 5'($urandom), $urandom);
                else
                    cyc(0, 0, 0, 0, 0, 0, rpc(), 4'hf, 5'($urandom_range(1, 31)), $urandom);
            end
        end

        wb(0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("drain", 32'(sq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
